// File: rtl/pt_dec.sv
// PT2262-style serial frame decoder.
// The line is synchronised, every high and low run is timed with one
// saturating counter, and the runs are classified into half-bits and syncs.
// A frame is reported on ad/vld only when it is an exact repeat of the
// frame that completed just before it.
module pt_dec #(
    parameter int U = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d,
    output logic [23:0] ad,
    output logic        vld,
    output logic        err
);

    // The run counter must be able to hold 16U, where it clamps.
    localparam int CW = $clog2(16 * U + 1);

    localparam logic [CW-1:0] T_HALF = CW'(U / 2);
    localparam logic [CW-1:0] T_2U   = CW'(2 * U);
    localparam logic [CW-1:0] T_4U   = CW'(4 * U);
    localparam logic [CW-1:0] T_16U  = CW'(16 * U);
    localparam logic [CW-1:0] T_16M1 = CW'(16 * U - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    // Synchroniser and run timing.
    logic          s1_reg;
    logic          s2_reg;
    logic          ds;
    logic          lvl_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          rise;
    logic          fall;
    logic          low_sat;

    // Decoder state.
    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic [4:0]  bits_reg;
    logic [4:0]  bits_next;
    logic [23:0] shift_reg;
    logic [23:0] shift_next;
    logic        hlong_reg;
    logic        hlong_next;
    logic [23:0] prev_reg;
    logic [23:0] prev_next;
    logic        match_reg;
    logic        match_next;
    logic [23:0] ad_reg;
    logic [23:0] ad_next;
    logic        vld_reg;
    logic        vld_next;
    logic        err_reg;
    logic        err_next;
    logic        fail;

    assign ds = s2_reg;

    // lvl_reg is the level of the run currently being timed, so a mismatch
    // with ds means that run has just ended and cnt_reg holds its length.
    assign rise    = ds && !lvl_reg;
    assign fall    = !ds && lvl_reg;
    // Fires once per low run, on the edge where the counter reaches 16U.
    assign low_sat = !ds && !lvl_reg && (cnt_reg == T_16M1);

    // Next run length: restart at 1 on a level change, clamp at 16U.
    always_comb begin
        cnt_next = cnt_reg;
        if (ds != lvl_reg) begin
            cnt_next = ONE;
        end else if (cnt_reg != T_16U) begin
            cnt_next = cnt_reg + ONE;
        end
    end

    // Synchroniser flops and the run-length counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg  <= 1'b0;
            s2_reg  <= 1'b0;
            lvl_reg <= 1'b0;
            cnt_reg <= '0;
        end else begin
            s1_reg  <= d;
            s2_reg  <= s1_reg;
            lvl_reg <= ds;
            cnt_reg <= cnt_next;
        end
    end

    // Run classification, frame assembly and repeat matching.
    always_comb begin
        state_next = state_reg;
        bits_next  = bits_reg;
        shift_next = shift_reg;
        hlong_next = hlong_reg;
        prev_next  = prev_reg;
        match_next = match_reg;
        ad_next    = ad_reg;
        vld_next   = 1'b0;
        err_next   = 1'b0;
        fail       = 1'b0;

        case (state_reg)
            HUNT: begin
                // Only a rise after a low run of at least 16U is a frame start.
                if (rise && (cnt_reg == T_16U)) begin
                    state_next = HIGH;
                    bits_next  = 5'd0;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (cnt_reg >= T_HALF && cnt_reg < T_2U) begin
                        hlong_next = 1'b0;
                        state_next = LOW;
                    end else if (cnt_reg >= T_2U && cnt_reg < T_4U) begin
                        hlong_next = 1'b1;
                        state_next = LOW;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            LOW: begin
                if (low_sat) begin
                    // A sync: short high followed by a long low.
                    if (hlong_reg) begin
                        fail = 1'b1;
                    end else if (bits_reg == 5'd24) begin
                        if (match_reg && (shift_reg == prev_reg)) begin
                            ad_next  = shift_reg;
                            vld_next = 1'b1;
                        end
                        prev_next  = shift_reg;
                        match_next = 1'b1;
                        bits_next  = 5'd0;
                        state_next = HUNT;
                    end else if (bits_reg != 5'd0) begin
                        fail = 1'b1;
                    end else begin
                        // Lone sync: stay aligned, wait for the next frame.
                        state_next = HUNT;
                    end
                end else if (rise) begin
                    // The low run just ended completes one half-bit.
                    if (!hlong_reg && cnt_reg >= T_2U && cnt_reg < T_4U) begin
                        if (bits_reg == 5'd24) begin
                            fail = 1'b1;
                        end else begin
                            shift_next = {shift_reg[22:0], 1'b0};
                            bits_next  = bits_reg + 5'd1;
                            state_next = HIGH;
                        end
                    end else if (hlong_reg && cnt_reg >= T_HALF && cnt_reg < T_2U) begin
                        if (bits_reg == 5'd24) begin
                            fail = 1'b1;
                        end else begin
                            shift_next = {shift_reg[22:0], 1'b1};
                            bits_next  = bits_reg + 5'd1;
                            state_next = HIGH;
                        end
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase

        // Any malformed run drops alignment and forgets the previous frame.
        if (fail) begin
            err_next   = 1'b1;
            bits_next  = 5'd0;
            match_next = 1'b0;
            state_next = HUNT;
        end
    end

    // Decoder state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= HUNT;
            bits_reg  <= 5'd0;
            shift_reg <= 24'd0;
            hlong_reg <= 1'b0;
            prev_reg  <= 24'd0;
            match_reg <= 1'b0;
            ad_reg    <= 24'd0;
            vld_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            bits_reg  <= bits_next;
            shift_reg <= shift_next;
            hlong_reg <= hlong_next;
            prev_reg  <= prev_next;
            match_reg <= match_next;
            ad_reg    <= ad_next;
            vld_reg   <= vld_next;
            err_reg   <= err_next;
        end
    end

    assign ad  = ad_reg;
    assign vld = vld_reg;
    assign err = err_reg;

endmodule

// File: tb/tb_pt_dec.sv
// Bench for pt_dec: frame-level line generator, protocol model and
// scoreboard. Each transmitted item updates the model, which queues the
// vld/err events it expects; the monitor pops one entry per DUT event.
module tb_pt_dec;

    localparam int U = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d   = 1'b0;
    logic [23:0] ad;
    logic        vld;
    logic        err;

    always #5 clk = ~clk;

    pt_dec #(.U(U)) dut (
        .clk(clk),
        .rst(rst),
        .d  (d),
        .ad (ad),
        .vld(vld),
        .err(err)
    );

    typedef struct {
        bit          is_vld;
        logic [23:0] ad;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   vld_times[$];
    bit   jit         = 1'b0;

    // Protocol model: alignment, half-bits collected so far, previous frame.
    bit          m_aligned = 1'b0;
    bit          m_bits[$];
    logic [23:0] m_prev    = 24'd0;
    bit          m_match   = 1'b0;
    logic [23:0] m_ad      = 24'd0;

    function automatic void m_push(input bit v, input logic [23:0] a);
        exp_t e;
        e.is_vld = v;
        e.ad     = a;
        exp_q.push_back(e);
    endfunction

    function automatic void m_error();
        m_push(1'b0, 24'd0);
        m_match   = 1'b0;
        m_aligned = 1'b0;
        m_bits.delete();
    endfunction

    function automatic void m_halfbit(input bit b);
        if (m_aligned) begin
            if (m_bits.size() == 24) m_error();
            else m_bits.push_back(b);
        end
    endfunction

    function automatic void m_sync();
        int unsigned val;
        if (m_aligned && m_bits.size() == 24) begin
            val = 0;
            foreach (m_bits[i]) val = val * 2 + m_bits[i];
            if (m_match && val[23:0] == m_prev) begin
                m_ad = val[23:0];
                m_push(1'b1, val[23:0]);
            end
            m_prev  = val[23:0];
            m_match = 1'b1;
        end else if (m_aligned && m_bits.size() != 0) begin
            m_error();
        end
        m_bits.delete();
        // The long low of a sync aligns the decoder whatever came before.
        m_aligned = 1'b1;
    endfunction

    function automatic void m_glitch();
        if (m_aligned) m_error();
    endfunction

    function automatic int dur(input int lo, input int hi, input int nom);
        int r;
        if (!jit) return nom;
        r = int'($urandom_range(0, 3));
        if (r == 0) return lo;
        if (r == 1) return hi;
        return int'($urandom_range(lo, hi));
    endfunction

    // Drive one level for n clocks; level changes land on falling edges.
    task automatic seg(input bit lvl, input int n);
        d = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_bit(input bit b);
        m_halfbit(b);
        if (b) begin
            seg(1'b1, dur(2 * U, 4 * U - 1, 3 * U));
            seg(1'b0, dur(U / 2, 2 * U - 1, U));
        end else begin
            seg(1'b1, dur(U / 2, 2 * U - 1, U));
            seg(1'b0, dur(2 * U, 4 * U - 1, 3 * U));
        end
    endtask

    task automatic tx_sync();
        m_sync();
        seg(1'b1, dur(U / 2, 2 * U - 1, U));
        seg(1'b0, dur(16 * U + 1, 34 * U, 31 * U));
    endtask

    task automatic tx_glitch();
        m_glitch();
        seg(1'b1, 1);
        seg(1'b0, 3 * U);
    endtask

    task automatic tx_bits(input logic [23:0] v, input int hi, input int lo);
        logic [23:0] w;
        w = v;
        for (int i = hi; i >= lo; i--) tx_bit(w[i]);
    endtask

    task automatic tx_frame(input logic [23:0] v);
        tx_bits(v, 23, 0);
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_match   = 1'b0;
        m_aligned = 1'b0;
        m_bits.delete();
        m_ad      = 24'd0;
    endtask

    // Monitor: consumes one scoreboard entry per vld/err pulse.
    initial begin
        exp_t        e;
        logic [23:0] last_ad;
        last_ad = 24'd0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (vld === 1'b1 && err === 1'b1) begin
                miscompares++;
                $display("FAIL vld_err_overlap: got both high at cycle %0d, want exclusive", cyc);
            end
            if (vld === 1'b1 || err === 1'b1) begin
                vectors++;
                $display("cycle %0d: vld=%b err=%b ad=%h", cyc, vld, err, ad);
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: got vld=%b err=%b, want no event", vld, err);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_vld != vld) begin
                        miscompares++;
                        $display("FAIL event_kind: got vld=%b err=%b, want vld=%b", vld, err, e.is_vld);
                    end else if (vld === 1'b1 && ad !== e.ad) begin
                        miscompares++;
                        $display("FAIL vld_ad: got %h, want %h", ad, e.ad);
                    end
                end
            end
            if (vld === 1'b1) vld_times.push_back(cyc);
            if (rst === 1'b0 && vld !== 1'b1 && ad !== last_ad) begin
                miscompares++;
                $display("FAIL ad_stable: got %h, want %h", ad, last_ad);
            end
            last_ad = ad;
        end
    end

    // Global time limit.
    initial begin
        #(10 * 150000);
        $display("FAIL timeout: got no finish, want finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] v;
        logic [23:0] last_v;
        int          r;
        int          n;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ad", ad, 24'd0);
        check("reset_vld", {23'd0, vld}, 24'd0);
        check("reset_err", {23'd0, err}, 24'd0);
        seg(1'b0, 20 * U);
        m_aligned = 1'b1;

        // Repeat of AAAA01: one vld at the second terminating sync.
        tx_sync();
        tx_frame(24'hAAAA01); tx_sync();
        tx_frame(24'hAAAA01); tx_sync();

        // Differing frame first, then a repeated pair.
        tx_frame(24'h000FFF); tx_sync();
        tx_frame(24'h123456); tx_sync();
        tx_frame(24'h123456); tx_sync();

        // One-clock high glitch mid-frame.
        tx_bits(24'h5A5A5A, 23, 14); tx_glitch(); tx_bits(24'h5A5A5A, 13, 0); tx_sync();
        tx_frame(24'h5A5A5A); tx_sync();
        tx_frame(24'h5A5A5A); tx_sync();

        // Short frame of 12 half-bits.
        tx_bits(24'hC3C3C3, 11, 0); tx_sync();
        tx_frame(24'h0F0F0F); tx_sync();
        tx_frame(24'h0F0F0F); tx_sync();

        // Reset in the middle of the second of two identical frames.
        tx_frame(24'h654321); tx_sync();
        tx_bits(24'h654321, 23, 14);
        pulse_reset();
        check("mid_reset_ad", ad, m_ad);
        tx_bits(24'h654321, 13, 0); tx_sync();
        tx_frame(24'h987654); tx_sync();
        tx_frame(24'h987654); tx_sync();

        // Five back-to-back identical frames with nominal timing.
        jit = 1'b0;
        vld_times.delete();
        for (int i = 0; i < 5; i++) begin
            tx_frame(24'hFFFFFF); tx_sync();
        end
        seg(1'b0, 8);
        check("b2b_vld_count", 24'(vld_times.size()), 24'd4);
        for (int i = 1; i < vld_times.size(); i++)
            check("b2b_vld_gap", 24'(vld_times[i] - vld_times[i - 1]), 24'd512);

        // Randomised items with timing jitter inside the tolerance windows.
        jit    = 1'b1;
        last_v = 24'hFFFFFF;
        for (int it = 0; it < 30; it++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5 || r == 9) begin
                v = ($urandom_range(0, 1) == 1) ? last_v : 24'($urandom);
                last_v = v;
                tx_frame(v); tx_sync();
            end else if (r == 6) begin
                n = int'($urandom_range(0, 27));
                for (int k = 0; k < n; k++) tx_bit(1'($urandom_range(0, 1)));
                tx_sync();
            end else if (r == 7) begin
                v = 24'($urandom);
                n = int'($urandom_range(1, 22));
                tx_bits(v, 23, n); tx_glitch(); tx_bits(v, n - 1, 0); tx_sync();
            end else begin
                tx_sync();
            end
        end
        seg(1'b0, 40);

        check("final_ad", ad, m_ad);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got none, want vld=%b ad=%h", e.is_vld, e.ad);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
